// File: rtl/ssd_pkg.sv
// Shared scan states, blanked segment value and active-low hex glyph table
// for the seven-segment scan controller.
package ssd_pkg;

   typedef enum logic {BLANK, DRIVE} scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Segment order {g,f,e,d,c,b,a}, 0 = lit; b and d are lower-case glyphs.
   localparam logic [6:0] GLYPH_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational hex nibble to active-low segment pattern lookup.
module ssd_glyph_decode
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPH_TBL[nibble];

endmodule

// File: rtl/ssd_scan_controller.sv
// Eight-digit seven-segment scan scheduler with double-buffered frame update.
// Optional macro SSD_DIMMING_EN adds a brightness input that shortens the DRIVE window.
//
// state | meaning
// BLANK | first BLANK_CYCLES of a slot, all anodes off
// DRIVE | rest of the slot, current digit driven from the active frame
module ssd_scan_controller
   import ssd_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int REFRESH_HZ   = 1_000,
   parameter int NUM_DIGITS   = 8,
   parameter int BLANK_CYCLES = 1_000
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_digits,
   input  logic [NUM_DIGITS-1:0]   upd_dp,
   input  logic [NUM_DIGITS-1:0]   upd_en,
`ifdef SSD_DIMMING_EN
   input  logic [3:0]              brightness,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int DWELL = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   scan_state_t state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;

   logic                         pend_full;
   logic [NUM_DIGITS-1:0][3:0]   pend_digits;
   logic [NUM_DIGITS-1:0]        pend_dp;
   logic [NUM_DIGITS-1:0]        pend_en;
   logic [NUM_DIGITS-1:0][3:0]   act_digits;
   logic [NUM_DIGITS-1:0]        act_dp;
   logic [NUM_DIGITS-1:0]        act_en;

   logic                  last_cnt;
   logic                  wrap;
   logic                  anode_on;
   logic [NUM_DIGITS-1:0] digit_sel;
   logic [3:0]            cur_nib;
   logic [6:0]            cur_glyph;

   assign last_cnt  = (cnt == CNT_W'(DWELL - 1));
   assign wrap      = last_cnt && (idx == IDX_W'(NUM_DIGITS - 1));
   assign digit_sel = NUM_DIGITS'(1) << idx;
   assign cur_nib   = act_digits[idx];
   assign upd_ready = ~pend_full;

   ssd_glyph_decode u_glyph (
      .nibble (cur_nib),
      .glyph  (cur_glyph)
   );

`ifdef SSD_DIMMING_EN
   logic [3:0] bright_q;
   int         on_len;

   // Lit portion of the DRIVE window scales in sixteenths of its length.
   assign on_len = ((DWELL - BLANK_CYCLES) * (int'(bright_q) + 1)) >> 4;
`endif

   always_comb begin
      anode_on = (state == DRIVE) && act_en[idx];
`ifdef SSD_DIMMING_EN
      anode_on = anode_on && ((int'(cnt) - BLANK_CYCLES) < on_len);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= BLANK;
         cnt         <= '0;
         idx         <= '0;
         an          <= '1;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         frame_done  <= 1'b0;
         pend_full   <= 1'b0;
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_en     <= '0;
         act_digits  <= '0;
         act_dp      <= '0;
         act_en      <= '0;
`ifdef SSD_DIMMING_EN
         bright_q    <= '0;
`endif
      end else begin
         cnt <= last_cnt ? '0 : cnt + 1'b1;

         case (state)
            BLANK: begin
               if (cnt == CNT_W'(BLANK_CYCLES - 1))
                  state <= DRIVE;
            end
            DRIVE: begin
               if (last_cnt) begin
                  state <= BLANK;
                  idx   <= wrap ? '0 : idx + 1'b1;
               end
            end
            default: state <= BLANK;
         endcase

         an         <= anode_on ? ~digit_sel : '1;
         seg        <= (state == DRIVE) ? cur_glyph : SEG_OFF;
         dp         <= (state == DRIVE) ? ~act_dp[idx] : 1'b1;
         frame_done <= wrap;

`ifdef SSD_DIMMING_EN
         if (cnt == '0)
            bright_q <= brightness;
`endif

         if (upd_valid && !pend_full) begin
            pend_digits <= upd_digits;
            pend_dp     <= upd_dp;
            pend_en     <= upd_en;
            pend_full   <= 1'b1;
         end

         // Frame swap only at the wrap, so a frame is never torn mid-scan.
         if (wrap && pend_full) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_en     <= pend_en;
            pend_full  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with a 10-cycle slot, 80-cycle frame.
module tb_ssd_scan_controller;

   logic        clk;
   logic        reset_n;
   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_digits;
   logic [7:0]  upd_dp;
   logic [7:0]  upd_en;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;
`ifdef SSD_DIMMING_EN
   logic [3:0]  brightness;
`endif

   int n_vec = 0;
   int n_err = 0;
   int on_cyc = 8;

   logic [6:0] glyph_ref [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   ssd_scan_controller #(
      .CLK_HZ       (800),
      .REFRESH_HZ   (10),
      .NUM_DIGITS   (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_digits (upd_digits),
      .upd_dp     (upd_dp),
      .upd_en     (upd_en),
`ifdef SSD_DIMMING_EN
      .brightness (brightness),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // pos is the frame-relative pin cycle: slot = pos/10, cycle-in-slot = pos%10 + 1.
   task automatic check_cycle(input int pos, input logic [7:0] en, input logic [7:0] dpm,
                              input logic [31:0] dig);
      int         s;
      int         k;
      logic [3:0] nib;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      s     = pos / 10;
      k     = pos % 10 + 1;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (k >= 3) begin
         nib   = dig[s*4 +: 4];
         e_seg = glyph_ref[nib];
         e_dp  = ~dpm[s];
         if (en[s] && (k < 3 + on_cyc))
            e_an[s] = 1'b0;
      end
      chk($sformatf("an p%0d", pos), an, e_an);
      chk($sformatf("seg p%0d", pos), seg, e_seg);
      chk($sformatf("dp p%0d", pos), dp, e_dp);
      chk($sformatf("frame_done p%0d", pos), frame_done, pos == 79);
   endtask

   task automatic check_range(input int lo, input int hi, input logic [7:0] en,
                              input logic [7:0] dpm, input logic [31:0] dig);
      for (int p = lo; p <= hi; p++) begin
         step();
         check_cycle(p, en, dpm, dig);
      end
   endtask

   task automatic offer(input logic [31:0] dig, input logic [7:0] dpm, input logic [7:0] en);
      upd_valid  = 1'b1;
      upd_digits = dig;
      upd_dp     = dpm;
      upd_en     = en;
   endtask

   localparam logic [31:0] P1 = 32'h76543210;
   localparam logic [31:0] P3 = 32'h89ABCDEF;
   localparam logic [31:0] PB = 32'h0123ABCD;
   localparam logic [31:0] PC = 32'hFEDC4567;
   localparam logic [31:0] PD = 32'h11111111;

   initial begin
      int dark_bad;
      int seen;
      reset_n    = 1'b0;
      upd_valid  = 1'b0;
      upd_digits = '0;
      upd_dp     = '0;
      upd_en     = '0;
`ifdef SSD_DIMMING_EN
      brightness = 4'd15;
`endif
      repeat (3) step();

      chk("rst an", an, 8'hFF);
      chk("rst seg", seg, 7'h7F);
      chk("rst dp", dp, 1'b1);
      chk("rst frame_done", frame_done, 1'b0);
      chk("rst ready", upd_ready, 1'b1);

      // Test 1: accept right after reset, shown from the following frame.
      reset_n = 1'b1;
      offer(P1, 8'h00, 8'hFF);
      step();
      chk("t1 ready drop", upd_ready, 1'b0);
      upd_valid = 1'b0;
      dark_bad = 0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (frame_done) begin
            seen = 1;
            break;
         end
         if (an !== 8'hFF) dark_bad++;
         step();
      end
      chk("t1 frame_done seen", seen, 1);
      chk("t1 dark before swap", dark_bad, 0);
      chk("t1 ready back", upd_ready, 1'b1);

      // Tests 1-2: three consecutive frames of P1, frame_done every 80 cycles.
      repeat (3) check_range(0, 79, 8'hFF, 8'h00, P1);

      // Test 3: sparse enables and one decimal point.
      offer(P3, 8'h01, 8'h05);
      check_range(0, 0, 8'hFF, 8'h00, P1);
      chk("t3 ready drop", upd_ready, 1'b0);
      upd_valid = 1'b0;
      check_range(1, 79, 8'hFF, 8'h00, P1);
      check_range(0, 79, 8'h05, 8'h01, P3);

      // Test 4: B mid-frame, then C held until after the wrap.
      check_range(0, 19, 8'h05, 8'h01, P3);
      offer(PB, 8'h80, 8'hFF);
      check_range(20, 20, 8'h05, 8'h01, P3);
      chk("t4 B accepted", upd_ready, 1'b0);
      offer(PC, 8'h0F, 8'hF0);
      for (int p = 21; p <= 79; p++) begin
         step();
         check_cycle(p, 8'h05, 8'h01, P3);
         chk($sformatf("t4 C refused p%0d", p), upd_ready, p == 79);
      end
      check_range(0, 0, 8'hFF, 8'h80, PB);
      chk("t4 C accepted", upd_ready, 1'b0);
      upd_valid = 1'b0;
      check_range(1, 79, 8'hFF, 8'h80, PB);
      check_range(0, 79, 8'hF0, 8'h0F, PC);

      // Test 5: reset in slot 5 DRIVE discards pending D and darkens the display.
      check_range(0, 9, 8'hF0, 8'h0F, PC);
      offer(PD, 8'hFF, 8'hFF);
      check_range(10, 10, 8'hF0, 8'h0F, PC);
      chk("t5 D pending", upd_ready, 1'b0);
      upd_valid = 1'b0;
      check_range(11, 53, 8'hF0, 8'h0F, PC);
      reset_n = 1'b0;
      step();
      chk("t5 an", an, 8'hFF);
      chk("t5 seg", seg, 7'h7F);
      chk("t5 dp", dp, 1'b1);
      chk("t5 ready", upd_ready, 1'b1);
      chk("t5 frame_done", frame_done, 1'b0);
      reset_n = 1'b1;
      repeat (2) check_range(0, 79, 8'h00, 8'h00, 32'h0);

`ifdef SSD_DIMMING_EN
      // Test 6: brightness 3 lights 2 of 8 DRIVE cycles, 15 lights all 8.
      offer(P1, 8'h00, 8'hFF);
      check_range(0, 0, 8'h00, 8'h00, 32'h0);
      upd_valid = 1'b0;
      check_range(1, 79, 8'h00, 8'h00, 32'h0);
      brightness = 4'd3;
      on_cyc = 2;
      check_range(0, 79, 8'hFF, 8'h00, P1);
      brightness = 4'd15;
      on_cyc = 8;
      check_range(0, 79, 8'hFF, 8'h00, P1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
